// File: rtl/grid_mover_multi_if.sv
// Handshake/bus bundle between the keyboard decoder, the grid mover and the VGA driver.
// The master side drives move pulses and mode/select; the slave side (grid_mover_multi) returns positions and status.
interface grid_mover_multi_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 4
);
  logic                           move_up;
  logic                           move_down;
  logic                           move_left;
  logic                           move_right;
  logic                           group_mode;
  logic [2:0]                     sel;
  logic [NUM_PLAYERS*COORD_W-1:0] player_x;
  logic [NUM_PLAYERS*COORD_W-1:0] player_y;
  logic                           moved;
  logic                           blocked;
  logic                           busy;

  modport master (
    output move_up, move_down, move_left, move_right, group_mode, sel,
    input  player_x, player_y, moved, blocked, busy
  );

  modport slave (
    input  move_up, move_down, move_left, move_right, group_mode, sel,
    output player_x, player_y, moved, blocked, busy
  );
endinterface

// File: rtl/grid_mover_multi.sv
// Grid positions of NUM_PLAYERS sprites: edge clamp, collision reject, post-move cooldown; result 3 cycles after the pulse.
// Pulses outside IDLE are dropped; define GRID_MOVER_WRAP_EN for horizontal wrap-around.
module grid_mover_multi #(
  parameter int NUM_PLAYERS     = 2,
  parameter int COORD_W         = 4,
  parameter int GRID_W          = 16,
  parameter int GRID_H          = 12,
  parameter int START_X         = 11,
  parameter int START_Y         = 7,
  parameter int COOLDOWN_CYCLES = 5000000
) (
  input logic               clk,
  input logic               rst,
  grid_mover_multi_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EVAL   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_COOL   = 2'd3;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  localparam int CNT_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic               group_q, group_d;
  logic [2:0]         sel_q, sel_d;
  logic               accept_q, accept_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               moved_q, moved_d;
  logic               blocked_q, blocked_d;
  logic [COORD_W-1:0] pos_x_q [NUM_PLAYERS];
  logic [COORD_W-1:0] pos_x_d [NUM_PLAYERS];
  logic [COORD_W-1:0] pos_y_q [NUM_PLAYERS];
  logic [COORD_W-1:0] pos_y_d [NUM_PLAYERS];
  logic [COORD_W-1:0] cand_x_q [NUM_PLAYERS];
  logic [COORD_W-1:0] cand_x_d [NUM_PLAYERS];
  logic [COORD_W-1:0] cand_y_q [NUM_PLAYERS];
  logic [COORD_W-1:0] cand_y_d [NUM_PLAYERS];

  logic [COORD_W-1:0]   nx [NUM_PLAYERS];
  logic [COORD_W-1:0]   ny [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] edge_hit;
  logic                 sel_bad;
  logic                 sel_ok;
  logic                 accept;
  logic                 any_pulse;

  assign any_pulse = bus.move_up | bus.move_down | bus.move_left | bus.move_right;

  // Raw per-sprite step; edges are tested before the add/subtract so coordinates never wrap by accident.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      nx[i]       = pos_x_q[i];
      ny[i]       = pos_y_q[i];
      edge_hit[i] = 1'b0;
      case (dir_q)
        D_UP: begin
          if (pos_y_q[i] == '0) edge_hit[i] = 1'b1;
          else                  ny[i] = pos_y_q[i] - 1'b1;
        end
        D_DOWN: begin
          if (pos_y_q[i] == Y_MAX) edge_hit[i] = 1'b1;
          else                     ny[i] = pos_y_q[i] + 1'b1;
        end
        D_LEFT: begin
`ifdef GRID_MOVER_WRAP_EN
          if (pos_x_q[i] == '0) nx[i] = X_MAX;
          else                  nx[i] = pos_x_q[i] - 1'b1;
`else
          if (pos_x_q[i] == '0) edge_hit[i] = 1'b1;
          else                  nx[i] = pos_x_q[i] - 1'b1;
`endif
        end
        default: begin
`ifdef GRID_MOVER_WRAP_EN
          if (pos_x_q[i] == X_MAX) nx[i] = '0;
          else                     nx[i] = pos_x_q[i] + 1'b1;
`else
          if (pos_x_q[i] == X_MAX) edge_hit[i] = 1'b1;
          else                     nx[i] = pos_x_q[i] + 1'b1;
`endif
        end
      endcase
    end
  end

  // Group moves keep relative positions, so only single mode needs the collision scan.
  always_comb begin
    sel_ok  = int'(sel_q) < NUM_PLAYERS;
    sel_bad = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (sel_q == 3'(i)) begin
        if (edge_hit[i]) sel_bad = 1'b1;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
          if (j != i && nx[i] == pos_x_q[j] && ny[i] == pos_y_q[j]) sel_bad = 1'b1;
        end
      end
    end
    accept = group_q ? ~(|edge_hit) : (sel_ok & ~sel_bad);
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    group_d   = group_q;
    sel_d     = sel_q;
    accept_d  = accept_q;
    cnt_d     = cnt_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    case (state_q)
      S_IDLE: begin
        if (any_pulse) begin
          if (bus.move_up)        dir_d = D_UP;
          else if (bus.move_down) dir_d = D_DOWN;
          else if (bus.move_left) dir_d = D_LEFT;
          else                    dir_d = D_RIGHT;
          group_d = bus.group_mode;
          sel_d   = bus.sel;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        accept_d = accept;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (group_q || sel_q == 3'(i)) begin
            cand_x_d[i] = nx[i];
            cand_y_d[i] = ny[i];
          end else begin
            cand_x_d[i] = pos_x_q[i];
            cand_y_d[i] = pos_y_q[i];
          end
        end
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (accept_q) begin
          pos_x_d = cand_x_q;
          pos_y_d = cand_y_q;
          moved_d = 1'b1;
        end else begin
          blocked_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = (COOLDOWN_CYCLES == 0) ? S_IDLE : S_COOL;
      end
      S_COOL: begin
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= D_UP;
      group_q   <= 1'b0;
      sel_q     <= '0;
      accept_q  <= 1'b0;
      cnt_q     <= '0;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_x_q[i]  <= COORD_W'(START_X);
        pos_y_q[i]  <= COORD_W'(START_Y + i);
        cand_x_q[i] <= COORD_W'(START_X);
        cand_y_q[i] <= COORD_W'(START_Y + i);
      end
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      group_q   <= group_d;
      sel_q     <= sel_d;
      accept_q  <= accept_d;
      cnt_q     <= cnt_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
    assign bus.player_x[g*COORD_W +: COORD_W] = pos_x_q[g];
    assign bus.player_y[g*COORD_W +: COORD_W] = pos_y_q[g];
  end

  assign bus.moved   = moved_q;
  assign bus.blocked = blocked_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_grid_mover_multi.sv
// Directed bench for grid_mover_multi with COOLDOWN_CYCLES=4; expected results queue up at stimulus time.
// Also runs with GRID_MOVER_WRAP_EN defined, where the final right move wraps instead of blocking.
module tb_grid_mover_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_mover_multi_if #(.NUM_PLAYERS(2), .COORD_W(4)) bus();

  grid_mover_multi #(
    .NUM_PLAYERS(2), .COORD_W(4), .GRID_W(16), .GRID_H(12),
    .START_X(11), .START_Y(7), .COOLDOWN_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       mv;
    logic [7:0] x;
    logic [7:0] y;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      $error("%s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.move_up    = 1'b0;
    bus.move_down  = 1'b0;
    bus.move_left  = 1'b0;
    bus.move_right = 1'b0;
    bus.group_mode = 1'b0;
    bus.sel        = 3'd0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_px"}, 32'(bus.player_x), 32'h bb);
    check({tag, "_py"}, 32'(bus.player_y), 32'h 87);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_moved"}, 32'(bus.moved), 32'd0);
    check({tag, "_blocked"}, 32'(bus.blocked), 32'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
  endtask

  // dirs = {up, down, left, right}
  task automatic request(input logic [3:0] dirs, input logic grp, input logic [2:0] s,
                         input logic mv, input logic [7:0] ex, input logic [7:0] ey,
                         input bit drop, input bit rst_mid);
    exp_t e;
    int   k;
    e.mv = mv;
    e.x  = ex;
    e.y  = ey;
    sb.push_back(e);
    bus.group_mode = grp;
    bus.sel        = s;
    {bus.move_up, bus.move_down, bus.move_left, bus.move_right} = dirs;
    tick();
    {bus.move_up, bus.move_down, bus.move_left, bus.move_right} = 4'b0000;
    check("busy_start", 32'(bus.busy), 32'd1);
    k = 1;
    while (!(bus.moved || bus.blocked) && k < 10) begin
      tick();
      k++;
    end
    check("latency", 32'(k), 32'd3);
    e = sb.pop_front();
    check("moved", 32'(bus.moved), 32'(e.mv));
    check("blocked", 32'(bus.blocked), 32'(!e.mv));
    check("px", 32'(bus.player_x), 32'(e.x));
    check("py", 32'(bus.player_y), 32'(e.y));
    if (rst_mid) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      return;
    end
    if (drop) bus.move_left = 1'b1;
    tick();
    k++;
    bus.move_left = 1'b0;
    check("pulse_len", 32'({bus.moved, bus.blocked}), 32'd0);
    while (bus.busy && k < 20) begin
      tick();
      k++;
    end
    check("busy_end", 32'(k), 32'd7);
  endtask

  initial begin
    int         pulses;
    logic [3:0] y0;
    logic [3:0] y1;

    do_reset();

    // single mode: sprite 0 right
    request(4'b0001, 1'b0, 3'd0, 1'b1, 8'h bc, 8'h 87, 1'b0, 1'b0);

    // collision with sprite 1, then out-of-range select
    do_reset();
    request(4'b0100, 1'b0, 3'd0, 1'b0, 8'h bb, 8'h 87, 1'b0, 1'b0);
    request(4'b1000, 1'b0, 3'd5, 1'b0, 8'h bb, 8'h 87, 1'b0, 1'b0);

    // group up to the top edge, then one more is all-or-nothing rejected
    for (int n = 1; n <= 7; n++) begin
      y0 = 4'(7 - n);
      y1 = 4'(8 - n);
      request(4'b1000, 1'b1, 3'd0, 1'b1, 8'h bb, {y1, y0}, 1'b0, 1'b0);
    end
    request(4'b1000, 1'b1, 3'd0, 1'b0, 8'h bb, 8'h 10, 1'b0, 1'b0);

    // a second left during cooldown is dropped
    do_reset();
    request(4'b0010, 1'b0, 3'd0, 1'b1, 8'h ba, 8'h 87, 1'b1, 1'b0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.moved || bus.blocked || bus.busy) pulses++;
    end
    check("drop_idle", 32'(pulses), 32'd0);
    check("drop_px", 32'(bus.player_x), 32'h ba);

    // up beats left when both arrive together
    request(4'b1010, 1'b0, 3'd0, 1'b1, 8'h ba, 8'h 86, 1'b0, 1'b0);

    // reset in cooldown restores everything at once
    request(4'b0001, 1'b0, 3'd1, 1'b1, 8'h ca, 8'h 86, 1'b0, 1'b1);
    check_reset_state("rst_cool");
    tick();
    check("rst_cool_idle", 32'(bus.busy), 32'd0);

    // walk sprite 0 to the right edge, then push past it
    request(4'b0001, 1'b0, 3'd0, 1'b1, 8'h bc, 8'h 87, 1'b0, 1'b0);
    request(4'b0001, 1'b0, 3'd0, 1'b1, 8'h bd, 8'h 87, 1'b0, 1'b0);
    request(4'b0001, 1'b0, 3'd0, 1'b1, 8'h be, 8'h 87, 1'b0, 1'b0);
    request(4'b0001, 1'b0, 3'd0, 1'b1, 8'h bf, 8'h 87, 1'b0, 1'b0);
`ifdef GRID_MOVER_WRAP_EN
    request(4'b0001, 1'b0, 3'd0, 1'b1, 8'h b0, 8'h 87, 1'b0, 1'b0);
`else
    request(4'b0001, 1'b0, 3'd0, 1'b0, 8'h bf, 8'h 87, 1'b0, 1'b0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
